// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions for the read controller, the memory model
// and the future write controller.
//   - rd_state_t     : read FSM state encoding
//   - DEF_*_WIDTH    : default bus widths
//   - TMR_W          : width of the bus wait timer
package mem_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int TMR_W          = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } rd_state_t;

endpackage

// File: rtl/wait_timer.sv
// Loadable saturating 8-bit counter with terminal-count compare.
// Ports:
//   clock, reset      : clock / async active-low reset
//   i_clr             : synchronous clear to 0 (highest priority)
//   i_load/i_load_val : synchronous load
//   i_en              : count up by one, stops at all-ones
//   o_tc              : count equals TIMEOUT
module wait_timer
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    localparam logic [TMR_W-1:0] TC_VAL = TIMEOUT[TMR_W-1:0];

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && (r_count != {TMR_W{1'b1}}))
            r_count <= r_count + 1'b1;  // saturate, never wrap
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/memory_read_controller.sv
// Read controller between the control unit and the memory bus.
// Accepts a one-cycle rd_start in IDLE, runs a req/ack handshake with a
// bounded wait, and returns the word on rd_data with a one-cycle rd_valid,
// or a one-cycle rd_error on timeout. All outputs are registered.
// Ports:
//   clock, reset         : clock / async active-low reset
//   rd_start, rd_addr    : read request from control unit
//   rd_busy, rd_valid,
//   rd_data, rd_error    : status / result back to accumulator path
//   mem_req, mem_addr    : request to memory
//   mem_ack, mem_rdata   : acknowledge and data from memory
module memory_read_controller
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_error,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    rd_state_t             r_state;
    logic                  r_busy, r_valid, r_error, r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;

    rd_state_t             w_state_nxt;
    logic                  w_busy_nxt, w_valid_nxt, w_error_nxt, w_req_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_tmr_clr, w_tmr_en, w_tmr_tc;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_clr      (w_tmr_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_tmr_en),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_error <= w_error_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_valid_nxt = 1'b0;
        w_error_nxt = 1'b0;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_start) begin
                    w_addr_nxt  = rd_addr;
                    w_req_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                // mem_ack here is ignored: memory has not seen the request yet
                w_tmr_clr   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // ack takes priority over a simultaneous terminal count
                if (mem_ack) begin
                    w_data_nxt  = mem_rdata;
                    w_req_nxt   = 1'b0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_tmr_tc) begin
                    w_req_nxt   = 1'b0;
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_en    = 1'b1;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rd_busy  = r_busy;
    assign rd_valid = r_valid;
    assign rd_error = r_error;
    assign rd_data  = r_data;
    assign mem_req  = r_req;
    assign mem_addr = r_addr;

endmodule

// File: tb/tb_memory_read_controller.sv
module tb_memory_read_controller;

    logic       clock, reset;
    logic       rd_start;
    logic [7:0] rd_addr;
    logic       rd_busy, rd_valid, rd_error;
    logic [7:0] rd_data;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // per-cycle observations of the last transaction (cycle 0 = rd_start cycle)
    logic       o_valid [0:31];
    logic       o_error [0:31];
    logic       o_req   [0:31];
    logic       o_busy  [0:31];
    logic [7:0] o_addr  [0:31];

    memory_read_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_start  (rd_start),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_error  (rd_error),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Stimulus only: called at a negedge; drives cycles 0..ncyc-1 and records
    // outputs at each cycle's negedge. ack_c / col_c = -1 disables them.
    task automatic txn(input logic [7:0] addr, input int ack_c, input logic [7:0] data,
                       input int col_c, input logic [7:0] col_addr, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            o_valid[c] = rd_valid;
            o_error[c] = rd_error;
            o_req[c]   = mem_req;
            o_busy[c]  = rd_busy;
            o_addr[c]  = mem_addr;
            rd_start   = (c == 0) || (c == col_c);
            rd_addr    = (c == col_c) ? col_addr : addr;
            mem_ack    = (c == ack_c);
            mem_rdata  = (c == ack_c) ? data : 8'hEE;
            @(negedge clock);
        end
        rd_start  = 0;
        mem_ack   = 0;
        mem_rdata = 8'h00;
    endtask

    task automatic test_reset();
        int bad;
        reset = 0; rd_start = 0; rd_addr = 0; mem_ack = 0; mem_rdata = 0;
        repeat (3) @(negedge clock);
        checks++;
        if ({rd_busy, rd_valid, rd_error, mem_req, rd_data, mem_addr} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {rd_busy, rd_valid, rd_error, mem_req, rd_data, mem_addr});
        end
        reset = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if ({rd_busy, rd_valid, rd_error, mem_req, rd_data, mem_addr} !== 20'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_outputs nonzero_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_basic();
        int nreq;
        txn(8'h3C, 2, 8'hA5, -1, 8'h00, 8);
        nreq = 0;
        for (int c = 0; c < 8; c++) nreq += int'(o_req[c]);
        checks++;
        if (nreq != 2 || o_req[1] !== 1'b1 || o_req[2] !== 1'b1) begin
            failures++;
            $display("FAIL basic_req cycles=%0d c1=%b c2=%b want=2,1,1", nreq, o_req[1], o_req[2]);
        end
        checks++;
        if (o_addr[1] !== 8'h3C || o_addr[2] !== 8'h3C) begin
            failures++;
            $display("FAIL basic_addr got=%h/%h want=3c", o_addr[1], o_addr[2]);
        end
        checks++;
        if (o_valid[3] !== 1'b1 || o_valid[2] !== 1'b0 || o_valid[4] !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid c2..4=%b%b%b want=010", o_valid[2], o_valid[3], o_valid[4]);
        end
        checks++;
        if (o_busy[0] !== 0 || o_busy[1] !== 1 || o_busy[3] !== 1 || o_busy[4] !== 0) begin
            failures++;
            $display("FAIL basic_busy c0,1,3,4=%b%b%b%b want=0110",
                     o_busy[0], o_busy[1], o_busy[3], o_busy[4]);
        end
        checks++;
        if (rd_data !== 8'hA5) begin
            failures++;
            $display("FAIL basic_data_held got=%h want=a5", rd_data);
        end
    endtask

    task automatic test_ack_in_idle();
        int nv;
        nv = 0;
        mem_ack = 1; mem_rdata = 8'h77;
        repeat (3) begin @(negedge clock); nv += int'(rd_valid); end
        mem_ack = 0; mem_rdata = 0;
        @(negedge clock);
        checks++;
        if (rd_data !== 8'hA5 || nv != 0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack data=%h valids=%0d req=%b want=a5,0,0", rd_data, nv, mem_req);
        end
    endtask

    task automatic test_delayed_ack();
        int ne;
        txn(8'h40, 9, 8'h5A, -1, 8'h00, 14);
        ne = 0;
        for (int c = 0; c < 14; c++) ne += int'(o_error[c]);
        checks++;
        if (o_valid[10] !== 1'b1 || o_valid[9] !== 1'b0 || o_valid[11] !== 1'b0) begin
            failures++;
            $display("FAIL delayed_valid c9..11=%b%b%b want=010", o_valid[9], o_valid[10], o_valid[11]);
        end
        checks++;
        if (rd_data !== 8'h5A || ne != 0) begin
            failures++;
            $display("FAIL delayed_data data=%h errors=%0d want=5a,0", rd_data, ne);
        end
    endtask

    task automatic test_timeout();
        int ne, nv, both;
        txn(8'h55, -1, 8'h00, -1, 8'h00, 22);
        ne = 0; nv = 0; both = 0;
        for (int c = 0; c < 22; c++) begin
            ne += int'(o_error[c]);
            nv += int'(o_valid[c]);
            both += int'(o_error[c] & o_valid[c]);
        end
        // WAIT runs cycles 2..17 (count 0..15); error visible in cycle 18
        checks++;
        if (o_error[18] !== 1'b1 || ne != 1 || nv != 0 || both != 0) begin
            failures++;
            $display("FAIL timeout_error c18=%b errors=%0d valids=%0d both=%0d want=1,1,0,0",
                     o_error[18], ne, nv, both);
        end
        checks++;
        if (o_req[17] !== 1 || o_req[18] !== 0 || o_busy[17] !== 1 || o_busy[18] !== 0) begin
            failures++;
            $display("FAIL timeout_release req17,18=%b%b busy17,18=%b%b want=10,10",
                     o_req[17], o_req[18], o_busy[17], o_busy[18]);
        end
        checks++;
        if (rd_data !== 8'h5A) begin
            failures++;
            $display("FAIL timeout_data got=%h want=5a", rd_data);
        end
    endtask

    task automatic test_busy_collision();
        int nreq, badaddr;
        txn(8'h22, 5, 8'hC3, 4, 8'h10, 10);
        nreq = 0; badaddr = 0;
        for (int c = 0; c < 10; c++) begin
            nreq += int'(o_req[c]);
            if (o_req[c] && o_addr[c] !== 8'h22) badaddr++;
        end
        checks++;
        if (nreq != 5 || badaddr != 0) begin
            failures++;
            $display("FAIL collision_req cycles=%0d badaddr=%0d want=5,0", nreq, badaddr);
        end
        checks++;
        if (o_valid[6] !== 1'b1 || rd_data !== 8'hC3 || o_busy[7] !== 1'b0) begin
            failures++;
            $display("FAIL collision_result valid6=%b data=%h busy7=%b want=1,c3,0",
                     o_valid[6], rd_data, o_busy[7]);
        end
    endtask

    task automatic test_back_to_back();
        int nreq;
        // second start lands in the DONE cycle and must be dropped
        txn(8'h31, 2, 8'h96, 3, 8'h32, 8);
        nreq = 0;
        for (int c = 0; c < 8; c++) nreq += int'(o_req[c]);
        checks++;
        if (nreq != 2 || o_busy[4] !== 1'b0 || o_busy[5] !== 1'b0 || rd_data !== 8'h96) begin
            failures++;
            $display("FAIL done_start req=%0d busy4,5=%b%b data=%h want=2,00,96",
                     nreq, o_busy[4], o_busy[5], rd_data);
        end
    endtask

    task automatic test_reset_mid();
        int nv, ne;
        rd_start = 1; rd_addr = 8'h77;
        @(negedge clock);
        rd_start = 0;
        repeat (4) @(negedge clock);   // now in WAIT
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre req=%b want=1", mem_req);
        end
        reset = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || rd_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async req=%b busy=%b want=0,0", mem_req, rd_busy);
        end
        repeat (2) @(negedge clock);
        reset = 1;
        nv = 0; ne = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            nv += int'(rd_valid); ne += int'(rd_error);
        end
        checks++;
        if (nv != 0 || ne != 0 || rd_data !== 8'h00) begin
            failures++;
            $display("FAIL midreset_quiet valids=%0d errors=%0d data=%h want=0,0,00", nv, ne, rd_data);
        end
        txn(8'h01, 2, 8'hFF, -1, 8'h00, 6);
        checks++;
        if (o_addr[1] !== 8'h01 || o_valid[3] !== 1'b1 || rd_data !== 8'hFF) begin
            failures++;
            $display("FAIL midreset_fresh addr=%h valid3=%b data=%h want=01,1,ff",
                     o_addr[1], o_valid[3], rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_in_idle();
        test_delayed_ack();
        test_timeout();
        test_busy_collision();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_read_controller.md
Name: memory_read_controller

Overview:
- Read-side companion to the processor's storage elements: accepts a read request from the accumulator datapath, drives a req/ack handshake on the memory bus and returns the data word to the accumulator load path.
- Sits between the control unit (LOAD/ADD-from-memory operands) and the memory subsystem.
- Includes a bounded wait (timeout) so a missing acknowledge cannot hang the processor.

Parameters:
- ADDR_WIDTH, 8, memory address width in bits
- DATA_WIDTH, 8, data word width in bits
- TIMEOUT, 15, maximum cycles in WAIT before abort; legal range 1..255

Ports:
- clock  input  1  single system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- rd_start  input  1  one-cycle pulse from control unit requesting a read
- rd_addr  input  ADDR_WIDTH  read address, sampled when rd_start is accepted
- rd_busy  output  1  high while a transaction is in progress
- rd_valid  output  1  one-cycle pulse: rd_data holds the returned word
- rd_data  output  DATA_WIDTH  returned word, held until the next accepted read
- rd_error  output  1  one-cycle pulse on timeout; rd_data unchanged
- mem_req  output  1  request to memory, level signal
- mem_addr  output  ADDR_WIDTH  address presented to memory, stable while mem_req=1
- mem_ack  input  1  acknowledge from memory; mem_rdata valid in the same cycle
- mem_rdata  input  DATA_WIDTH  read data from memory

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rd_busy=0, rd_valid=0, rd_error=0, rd_data=0, mem_req=0, mem_addr=0, timeout counter=0. All outputs are registered.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - rd_start=1 -> latch rd_addr into mem_addr; go to REQ; rd_busy=1 from the next cycle.
  - rd_start=0 -> stay in IDLE.
- REQ:
  - Drive mem_req=1 for exactly one cycle with mem_addr stable.
  - Clear the counter; go to WAIT.
  - mem_ack seen in REQ is ignored, because the request is not yet visible to memory.
- WAIT:
  - mem_req stays 1.
  - mem_ack=1 -> capture mem_rdata into rd_data; drop mem_req; go to DONE.
  - Else increment the counter. When the counter reaches TIMEOUT with no ack -> drop mem_req; assert rd_error for one cycle; go to IDLE.
  - If mem_ack and counter==TIMEOUT occur in the same cycle, ack wins: the data is captured and no error is raised.
- DONE:
  - rd_valid=1 for exactly one cycle; rd_busy=0 from the next cycle; return to IDLE.
- Latency: rd_start at cycle 0 with mem_ack at the first WAIT cycle (cycle 2) -> rd_valid at cycle 3. Minimum start-to-valid latency is 3 cycles.
- rd_start while rd_busy=1 is ignored; no queueing.
- rd_start in the same cycle as the DONE->IDLE return is also ignored. A new request is accepted only in IDLE.
- rd_error path clears rd_busy on the same edge the error pulse is registered.
- mem_ack arriving while in IDLE or DONE is ignored; rd_data is not disturbed.
- Reset asserted mid-transaction aborts immediately:
  - mem_req drops asynchronously.
  - No rd_valid or rd_error pulse is produced.
- rd_valid and rd_error are never high in the same cycle.
- Counter width: 8 bits, saturating; it never wraps within a transaction.

Decomposition:
- Shared package `mem_bus_pkg`:
  - state encoding constants: IDLE=2'b00, REQ=2'b01, WAIT=2'b10, DONE=2'b11
  - default ADDR_WIDTH/DATA_WIDTH constants, shared with the memory model and the future write controller
- Sub-module `wait_timer`: loadable 8-bit saturating counter with clear/enable inputs and a terminal-count output compared against TIMEOUT. Reusable by the write side.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, run 10 cycles with no rd_start -> all outputs 0, mem_req never 1.
- Basic read: rd_addr=8'h3C with a pulse on rd_start; memory acks on the 1st WAIT cycle with mem_rdata=8'hA5 -> mem_addr=8'h3C while mem_req=1; rd_valid pulses one cycle at start+3; rd_data=8'hA5 and held.
- Delayed ack: memory acks after 7 WAIT cycles with 8'h5A (TIMEOUT=15) -> rd_valid at start+10; rd_data=8'h5A; rd_error stays 0.
- Timeout: memory never acks (TIMEOUT=15) -> rd_error pulses once; mem_req drops; rd_busy=0; rd_data keeps its previous value 8'h5A.
- Busy collision: second rd_start with addr 8'h10 during WAIT -> ignored; the transaction completes with the original address and data; no second mem_req.
- Reset mid-operation: assert reset during WAIT -> mem_req=0 immediately; after release, no rd_valid/rd_error; a fresh read of 8'h01 returning 8'hFF then completes normally.
